wb_cmd_master: RTL and testbench

Synthesizable Wishbone B3 classic single-cycle master. It is the initiator counterpart to the wb_dut register slave, for use in RTL instead of the UVM driver. It accepts one command at a time on a valid/ready request port, runs a single read or write on the Wishbone bus, and returns data plus a completion status on a valid/ready response port. Handles ERR, RTY with bounded retry, and a cycle timeout.

---
 rtl/wb_master_pkg.sv | 24 ++
 rtl/wb_cmd_master.sv | 165 ++++++++++++++++
 tb/tb_wb_cmd_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone command master: completion status codes,
// FSM states and counter sizing.
package wb_master_pkg;

  typedef enum logic [1:0] {
    WB_OK            = 2'b00,
    WB_ERR           = 2'b01,
    WB_TIMEOUT       = 2'b10,
    WB_RTY_EXHAUSTED = 2'b11
  } wb_status_e;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    BACKOFF,
    RESP
  } wb_mst_state_e;

  // Bits needed to count from 0 up to maxval inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/wb_cmd_master.sv
// Wishbone B3 classic single-transfer master: one command in, one bus cycle
// (with RTY reissue and timeout), one status response out.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic            cmd_we_i,
  input  logic [AW-1:0]   cmd_adr_i,
  input  logic [DW-1:0]   cmd_dat_i,
  input  logic [DW/8-1:0] cmd_sel_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [DW-1:0]   rsp_dat_o,
  output logic [1:0]      rsp_status_o,
  output logic [AW-1:0]   ADR_O,
  output logic [DW-1:0]   DAT_O,
  input  logic [DW-1:0]   DAT_I,
  output logic [DW/8-1:0] SEL_O,
  output logic            WE_O,
  output logic            CYC_O,
  output logic            STB_O,
  input  logic            ACK_I,
  input  logic            ERR_I,
  input  logic            RTY_I
);

  localparam int unsigned SW  = DW / 8;
  localparam int unsigned WCW = cnt_width(TIMEOUT);
  localparam int unsigned RCW = cnt_width(MAX_RETRY);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = '1;
  localparam logic [RCW-1:0] RETRY_MAX = RCW'(MAX_RETRY);

  wb_mst_state_e   state_q, state_d;
  wb_status_e      status_q, status_d;
  logic [WCW-1:0]  wait_q, wait_d;
  logic [RCW-1:0]  retry_q, retry_d;
  logic            cmd_ready_d, rsp_valid_d, we_d, cyc_d, stb_d;
  logic [DW-1:0]   rsp_dat_d, dat_d;
  logic [AW-1:0]   adr_d;
  logic [SW-1:0]   sel_d;

  assign rsp_status_o = status_q;

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    wait_d      = wait_q;
    retry_d     = retry_q;
    cmd_ready_d = cmd_ready_o;
    rsp_valid_d = rsp_valid_o;
    rsp_dat_d   = rsp_dat_o;
    adr_d       = ADR_O;
    dat_d       = DAT_O;
    sel_d       = SEL_O;
    we_d        = WE_O;
    cyc_d       = CYC_O;
    stb_d       = STB_O;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_o) begin
          adr_d       = cmd_adr_i;
          dat_d       = cmd_dat_i;
          sel_d       = cmd_sel_i;
          we_d        = cmd_we_i;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          wait_d      = '0;
          retry_d     = '0;
          cmd_ready_d = 1'b0;
          state_d     = BUS;
        end
      end
      BUS: begin
        // Terminations are tested ahead of the timeout so a late ACK still wins.
        if (ERR_I || ACK_I || (RTY_I && retry_q == RETRY_MAX)) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_dat_d   = '0;
          state_d     = RESP;
          if (ERR_I) begin
            status_d = WB_ERR;
          end else if (ACK_I) begin
            status_d  = WB_OK;
            rsp_dat_d = WE_O ? '0 : DAT_I;
          end else begin
            status_d = WB_RTY_EXHAUSTED;
          end
        end else if (RTY_I) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          retry_d = retry_q + RCW'(1);
          wait_d  = '0;
          state_d = BACKOFF;
        end else begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + WCW'(1);
          if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_dat_d   = '0;
            status_d    = WB_TIMEOUT;
            state_d     = RESP;
          end
        end
      end
      BACKOFF: begin
        cyc_d   = 1'b1;
        stb_d   = 1'b1;
        state_d = BUS;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q     <= IDLE;
      status_q    <= WB_OK;
      wait_q      <= '0;
      retry_q     <= '0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      ADR_O       <= '0;
      DAT_O       <= '0;
      SEL_O       <= '0;
      WE_O        <= 1'b0;
      CYC_O       <= 1'b0;
      STB_O       <= 1'b0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      wait_q      <= wait_d;
      retry_q     <= retry_d;
      cmd_ready_o <= cmd_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_dat_o   <= rsp_dat_d;
      ADR_O       <= adr_d;
      DAT_O       <= dat_d;
      SEL_O       <= sel_d;
      WE_O        <= we_d;
      CYC_O       <= cyc_d;
      STB_O       <= stb_d;
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed vector table plus randomized slave
// scripts checked against a transaction-level reference model.
module tb_wb_cmd_master;

  localparam int TMO  = 8;
  localparam int MAXR = 3;
  localparam int T_NONE = 0, T_ACK = 1, T_ERR = 2, T_RTY = 3, T_AE = 4, T_AR = 5, T_ER = 6;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
  logic [31:0] cmd_adr_i = '0, cmd_dat_i = '0;
  logic [3:0]  cmd_sel_i = '0;
  logic        rsp_valid_o, rsp_ready_i = 1'b0;
  logic [31:0] rsp_dat_o;
  logic [1:0]  rsp_status_o;
  logic [31:0] ADR_O, DAT_O, DAT_I = '0;
  logic [3:0]  SEL_O;
  logic        WE_O, CYC_O, STB_O;
  logic        ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;

  always #5 CLK_I = ~CLK_I;

  wb_cmd_master #(.AW(32), .DW(32), .TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
    .rsp_status_o(rsp_status_o),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .SEL_O(SEL_O), .WE_O(WE_O),
    .CYC_O(CYC_O), .STB_O(STB_O), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  // One command plus the slave's script: per STB phase, wait states then a termination.
  typedef struct {
    logic            we;
    logic [31:0]     adr, dat, rdat;
    logic [3:0]      sel;
    int              nph;
    logic [5:0][7:0] waits;
    logic [5:0][2:0] terms;
    int              bp;
    logic [1:0]      e_st;
    logic [31:0]     e_dat;
    int              e_ph, e_stb;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_term(input int code, input logic [31:0] rd);
    ACK_I = (code == T_ACK || code == T_AE || code == T_AR);
    ERR_I = (code == T_ERR || code == T_AE || code == T_ER);
    RTY_I = (code == T_RTY || code == T_AR || code == T_ER);
    DAT_I = ACK_I ? rd : $urandom;
  endtask

  task automatic noise();
    drive_term(int'($urandom_range(0, 6)), $urandom);
  endtask

  function automatic vec_t mkv(input logic we, input logic [31:0] adr, dat, rdat,
                               input logic [3:0] sel, input int nph,
                               input int w0, t0, w1, t1, w2, t2, w3, t3, bp,
                               input logic [1:0] e_st, input logic [31:0] e_dat,
                               input int e_ph, e_stb);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.rdat = rdat; v.sel = sel; v.nph = nph;
    v.waits = '0; v.terms = '0;
    v.waits[0] = 8'(w0); v.terms[0] = 3'(t0);
    v.waits[1] = 8'(w1); v.terms[1] = 3'(t1);
    v.waits[2] = 8'(w2); v.terms[2] = 3'(t2);
    v.waits[3] = 8'(w3); v.terms[3] = 3'(t3);
    v.bp = bp; v.e_st = e_st; v.e_dat = e_dat; v.e_ph = e_ph; v.e_stb = e_stb;
    return v;
  endfunction

  // Transaction-level reference: walk the slave script phase by phase.
  function automatic void model(inout vec_t v);
    int retries = 0;
    v.e_st = 2'b10; v.e_dat = '0; v.e_ph = 0; v.e_stb = 0;
    for (int i = 0; i < 6; i++) begin
      int w = (i < v.nph) ? int'(v.waits[i]) : 1000;
      int t = (i < v.nph) ? int'(v.terms[i]) : T_NONE;
      v.e_ph++;
      if (t == T_NONE || w >= TMO) begin
        v.e_stb += TMO; v.e_st = 2'b10; return;
      end
      v.e_stb += w + 1;
      if (t == T_ERR || t == T_AE || t == T_ER) begin v.e_st = 2'b01; return; end
      if (t == T_ACK || t == T_AR) begin
        v.e_st = 2'b00; v.e_dat = v.we ? 32'h0 : v.rdat; return;
      end
      if (retries == MAXR) begin v.e_st = 2'b11; return; end
      retries++;
    end
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int k, lat, obs_ph, stb_sum, cnt, gap, p;
    logic prev, done, gap_bad, bus_bad, stab_bad, rdy_bad;
    @(negedge CLK_I);
    cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_adr_i = v.adr; cmd_dat_i = v.dat; cmd_sel_i = v.sel;
    noise();
    k = 0;
    while (!cmd_ready_o && k < 20) begin @(negedge CLK_I); noise(); k++; end
    chk({tag, " accept"}, cmd_ready_o, 1);
    @(negedge CLK_I);
    cmd_valid_i = 1'b0; cmd_we_i = $urandom; cmd_adr_i = $urandom; cmd_dat_i = $urandom; cmd_sel_i = 4'($urandom);
    chk({tag, " cyc_cycle1"}, {CYC_O, STB_O, cmd_ready_o}, 3'b110);
    lat = 1; obs_ph = 0; stb_sum = 0; cnt = 0; gap = 0; prev = 1'b0;
    done = 1'b0; gap_bad = 1'b0; bus_bad = 1'b0;
    while (lat < 200) begin
      if (rsp_valid_o) begin done = 1'b1; break; end
      if (CYC_O) begin
        if (!prev) begin
          if (obs_ph > 0 && gap != 1) gap_bad = 1'b1;
          obs_ph++; cnt = 0;
        end
        cnt++; stb_sum++; gap = 0;
        if (!STB_O || ADR_O !== v.adr || DAT_O !== v.dat || SEL_O !== v.sel ||
            WE_O !== v.we || cmd_ready_o) bus_bad = 1'b1;
        p = obs_ph - 1;
        if (p < v.nph && int'(v.terms[p]) != T_NONE && cnt == int'(v.waits[p]) + 1)
          drive_term(int'(v.terms[p]), v.rdat);
        else
          drive_term(T_NONE, 32'h0);
      end else begin
        if (STB_O) bus_bad = 1'b1;
        gap++;
        noise();
      end
      prev = CYC_O;
      @(negedge CLK_I);
      lat++;
    end
    noise();
    chk({tag, " rsp_seen"}, done, 1);
    chk({tag, " latency"}, lat, v.e_stb + v.e_ph);
    chk({tag, " phases"}, obs_ph, v.e_ph);
    chk({tag, " stb_cycles"}, stb_sum, v.e_stb);
    chk({tag, " backoff_gap"}, gap_bad, 0);
    chk({tag, " bus_stable"}, bus_bad, 0);
    chk({tag, " status"}, rsp_status_o, v.e_st);
    chk({tag, " rsp_dat"}, rsp_dat_o, v.e_dat);
    chk({tag, " resp_bus_idle"}, {CYC_O, STB_O, cmd_ready_o}, 3'b000);
    stab_bad = 1'b0; rdy_bad = 1'b0;
    for (int i = 0; i < v.bp; i++) begin
      @(negedge CLK_I);
      noise();
      if (!rsp_valid_o || rsp_dat_o !== v.e_dat || rsp_status_o !== v.e_st) stab_bad = 1'b1;
      if (cmd_ready_o || CYC_O) rdy_bad = 1'b1;
    end
    if (v.bp > 0) begin
      chk({tag, " bp_hold"}, stab_bad, 0);
      chk({tag, " bp_ready_low"}, rdy_bad, 0);
    end
    rsp_ready_i = 1'b1;
    @(negedge CLK_I);
    rsp_ready_i = 1'b0;
    chk({tag, " after_handshake"}, {rsp_valid_o, cmd_ready_o, CYC_O}, 3'b010);
  endtask

  initial begin
    vec_t v;
    tbl[0]  = mkv(0, 32'h10, 32'h0, 32'hDEADBEEF, 4'hF, 1, 0, T_ACK, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 1, 1);
    tbl[1]  = mkv(1, 32'h20, 32'h12345678, 32'h0, 4'hF, 1, 5, T_ACK, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1, 6);
    tbl[2]  = mkv(0, 32'h30, 32'h0, 32'hA5A5A5A5, 4'hF, 3, 0, T_RTY, 0, T_RTY, 0, T_ACK, 0, 0, 1, 2'b00, 32'hA5A5A5A5, 3, 3);
    tbl[3]  = mkv(0, 32'h34, 32'h0, 32'h5555AAAA, 4'hF, 4, 0, T_RTY, 0, T_RTY, 0, T_RTY, 0, T_RTY, 0, 2'b11, 32'h0, 4, 4);
    tbl[4]  = mkv(0, 32'h40, 32'h0, 32'h0, 4'hF, 1, 0, T_NONE, 0, 0, 0, 0, 0, 0, 2, 2'b10, 32'h0, 1, 8);
    tbl[5]  = mkv(0, 32'h44, 32'h0, 32'h11112222, 4'hF, 1, 2, T_AE, 0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h0, 1, 3);
    tbl[6]  = mkv(1, 32'h48, 32'h9ABCDEF0, 32'h0, 4'h3, 1, 7, T_ACK, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 1, 8);
    tbl[7]  = mkv(0, 32'h4C, 32'h0, 32'h13572468, 4'hF, 1, 8, T_ACK, 0, 0, 0, 0, 0, 0, 0, 2'b10, 32'h0, 1, 8);
    tbl[8]  = mkv(0, 32'h50, 32'h0, 32'h0BADF00D, 4'hC, 1, 1, T_ACK, 0, 0, 0, 0, 0, 0, 10, 2'b00, 32'h0BADF00D, 1, 2);
    tbl[9]  = mkv(0, 32'h54, 32'h0, 32'h77778888, 4'h1, 1, 0, T_AR, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h77778888, 1, 1);
    tbl[10] = mkv(1, 32'h58, 32'hFEEDFACE, 32'h0, 4'h6, 2, 1, T_RTY, 3, T_ER, 0, 0, 0, 0, 0, 2'b01, 32'h0, 2, 6);
    tbl[11] = mkv(0, 32'h5C, 32'h0, 32'hCAFEF00D, 4'hF, 4, 0, T_RTY, 2, T_RTY, 0, T_RTY, 4, T_ACK, 3, 2'b00, 32'hCAFEF00D, 4, 10);
    tbl[12] = mkv(0, 32'h60, 32'h0, 32'h0, 4'hF, 2, 3, T_RTY, 0, T_NONE, 0, 0, 0, 0, 0, 2'b10, 32'h0, 2, 12);

    #12;
    chk("reset ctl", {cmd_ready_o, rsp_valid_o, WE_O, CYC_O, STB_O, rsp_status_o, SEL_O}, 0);
    chk("reset adr_dat", {ADR_O, DAT_O}, 0);
    chk("reset rsp_dat", rsp_dat_o, 0);
    @(negedge CLK_I); RST_I = 1'b1;
    @(negedge CLK_I);
    chk("ready after reset", cmd_ready_o, 1);

    for (int i = 0; i < 13; i++) run_vec($sformatf("dir%0d", i), tbl[i]);

    for (int n = 0; n < 40; n++) begin
      v.we = 1'($urandom); v.adr = $urandom; v.dat = $urandom; v.rdat = $urandom;
      v.sel = 4'($urandom); v.nph = $urandom_range(1, 5);
      v.waits = '0; v.terms = '0;
      for (int i = 0; i < 6; i++) begin
        int r = $urandom_range(0, 9);
        v.waits[i] = 8'(($urandom_range(0, 7) == 0) ? $urandom_range(6, 9) : $urandom_range(0, 3));
        v.terms[i] = 3'((r == 0) ? T_NONE : (r <= 3) ? T_RTY : (r <= 5) ? T_ACK :
                        (r == 6) ? T_ERR : (r == 7) ? T_AE : (r == 8) ? T_AR : T_ER);
      end
      v.bp = $urandom_range(0, 4);
      model(v);
      run_vec($sformatf("rnd%0d", n), v);
    end

    // Reset asserted between clock edges while the slave is inserting wait states.
    @(negedge CLK_I);
    drive_term(T_NONE, 32'h0);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h70; cmd_dat_i = 32'h0F0F0F0F; cmd_sel_i = 4'hF;
    for (int k = 0; k < 20 && !cmd_ready_o; k++) @(negedge CLK_I);
    @(negedge CLK_I); cmd_valid_i = 1'b0;
    @(negedge CLK_I);
    chk("midrst in_bus", {CYC_O, STB_O}, 2'b11);
    #2 RST_I = 1'b0;
    #1;
    chk("midrst ctl", {cmd_ready_o, rsp_valid_o, WE_O, CYC_O, STB_O, rsp_status_o, SEL_O}, 0);
    chk("midrst adr_dat", {ADR_O, DAT_O}, 0);
    chk("midrst rsp_dat", rsp_dat_o, 0);
    @(negedge CLK_I); @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    chk("midrst ready", {cmd_ready_o, CYC_O}, 2'b10);
    run_vec("post_rst", tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
